// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-port I2C master arbiter and its requesters.
package i2c_arb_pkg;

  localparam int N_PORTS            = 2;
  localparam int DEF_TIMEOUT_CYCLES = 2000000;  // 20 ms at 100 MHz
  localparam int DEF_GAP_CYCLES     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/i2c_arb_watchdog.sv
// Loadable down-counter with a terminal-count flag; used for both the
// bus-idle gap and the owner watchdog.
module i2c_arb_watchdog #(
  parameter int W = 4
) (
  input  logic         clk_fpga,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Load wins; otherwise count down while enabled and hold at zero.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master between two
// requester FSMs, with a bus-idle gap and an owner watchdog.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic [N_PORTS-1:0]   req,
  input  logic [N_PORTS-1:0]   stb,
  input  logic [N_PORTS-1:0]   msg,
  input  logic [8*N_PORTS-1:0] addr,
  input  logic [8*N_PORTS-1:0] di,
  output logic [N_PORTS-1:0]   gnt,
  output logic [N_PORTS-1:0]   done,
  output logic [N_PORTS-1:0]   err,
  output logic [7:0]           dout,
  output logic                 timeout,
  output logic                 busy,
  output logic                 twi_msg,
  output logic                 twi_stb,
  output logic [7:0]           twi_addr,
  output logic [7:0]           twi_di,
  input  logic [7:0]           twi_do,
  input  logic                 twi_done,
  input  logic                 twi_err
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arb_state_t   state, state_nx;
  logic         owner, last_owner;
  logic [1:0]   lockout, eligible, own_onehot;
  logic         grant, grant_port, rel_drop, rel_to;
  logic         wd_tc, gap_tc, wd_load, own_active;

  assign own_onehot = owner ? 2'b10 : 2'b01;
  assign eligible   = req & ~lockout;
  assign wd_load    = grant | ((state == ST_OWN) & twi_done);

  i2c_arb_watchdog #(.W(WD_W)) u_wd (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .load     (wd_load),
    .load_val (WD_LOAD),
    .en       (state == ST_OWN),
    .tc       (wd_tc)
  );

  i2c_arb_watchdog #(.W(GAP_W)) u_gap (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .load     (rel_drop | rel_to),
    .load_val (GAP_LOAD),
    .en       (state == ST_GAP),
    .tc       (gap_tc)
  );

  // State register plus registered grant, round-robin history and lockout.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lockout    <= 2'b00;
      gnt        <= 2'b00;
      timeout    <= 1'b0;
    end else begin
      state   <= state_nx;
      timeout <= rel_to;
      // A locked-out port is freed once it is seen with req low.
      lockout <= (lockout | (rel_to ? own_onehot : 2'b00)) & req;
      if (grant) begin
        owner <= grant_port;
        gnt   <= grant_port ? 2'b10 : 2'b01;
      end
      if (rel_drop || rel_to) begin
        gnt        <= 2'b00;
        last_owner <= owner;
      end
    end
  end

  // Next-state: arbitrate in IDLE, release on req drop or watchdog expiry.
  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    rel_drop   = 1'b0;
    rel_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eligible != 2'b00) begin
          grant      = 1'b1;
          grant_port = (eligible == 2'b11) ? ~last_owner : eligible[1];
          state_nx   = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!(owner ? req[1] : req[0])) begin
          rel_drop = 1'b1;
          state_nx = ST_GAP;
        end else if (wd_tc && !twi_done) begin
          rel_to   = 1'b1;
          state_nx = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_tc) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs: mux the owner onto the master and route completion back to it.
  always_comb begin
    own_active = (state == ST_OWN) && !reset;
    twi_stb    = 1'b0;
    twi_msg    = 1'b0;
    twi_addr   = 8'h00;
    twi_di     = 8'h00;
    done       = 2'b00;
    err        = 2'b00;
    busy       = (state != ST_IDLE) && !reset;
    if (own_active) begin
      twi_stb  = (owner ? stb[1] : stb[0]) & ~(wd_tc & ~twi_done);
      twi_msg  = owner ? msg[1] : msg[0];
      twi_addr = owner ? addr[15:8] : addr[7:0];
      twi_di   = owner ? di[15:8] : di[7:0];
      done     = twi_done ? own_onehot : 2'b00;
      err      = twi_err ? own_onehot : 2'b00;
    end
  end

  assign dout = twi_do;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_i2c_bus_arbiter;

  localparam int T   = 50;
  localparam int GAP = 4;

  logic        clk_fpga = 1'b0;
  logic        reset;
  logic [1:0]  req, stb, msg;
  logic [15:0] addr, di;
  logic [7:0]  twi_do;
  logic        twi_done, twi_err;
  logic [1:0]  gnt, done, err;
  logic [7:0]  dout, twi_addr, twi_di;
  logic        timeout, busy, twi_msg, twi_stb;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, cycles since grant/last done,
  // earliest cycle at which arbitration may happen, lockouts, history.
  int m_own, m_since, m_arb_at, m_cyc, m_last;
  bit m_lock [2];
  bit m_to;

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(GAP)) dut (
    .clk_fpga (clk_fpga), .reset (reset),
    .req (req), .stb (stb), .msg (msg), .addr (addr), .di (di),
    .gnt (gnt), .done (done), .err (err), .dout (dout),
    .timeout (timeout), .busy (busy),
    .twi_msg (twi_msg), .twi_stb (twi_stb), .twi_addr (twi_addr), .twi_di (twi_di),
    .twi_do (twi_do), .twi_done (twi_done), .twi_err (twi_err)
  );

  always #5 clk_fpga = ~clk_fpga;

  initial begin
    #1000000;
    $display("FAIL tb_time_limit: got still running, expected finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_since = 0; m_arb_at = 0; m_last = 1;
    m_lock[0] = 0; m_lock[1] = 0; m_to = 0;
  endtask

  task automatic model_check();
    bit owned, term;
    logic [1:0] e_gnt, e_done, e_err;
    logic e_stb, e_msg, e_busy;
    logic [7:0] e_addr, e_di;
    owned = (m_own >= 0);
    term  = owned && (m_since == T - 1) && !twi_done;
    e_gnt = 0; e_done = 0; e_err = 0; e_stb = 0; e_msg = 0; e_addr = 0; e_di = 0;
    if (owned) begin
      e_gnt  = (m_own == 1) ? 2'b10 : 2'b01;
      e_stb  = stb[m_own] && !term;
      e_msg  = msg[m_own];
      e_addr = addr[m_own*8 +: 8];
      e_di   = di[m_own*8 +: 8];
      e_done = twi_done ? e_gnt : 2'b00;
      e_err  = twi_err ? e_gnt : 2'b00;
    end
    e_busy = owned || (m_cyc < m_arb_at);
    chk("gnt", gnt, e_gnt);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("twi_stb", twi_stb, e_stb);
    chk("twi_msg", twi_msg, e_msg);
    chk("twi_addr", twi_addr, e_addr);
    chk("twi_di", twi_di, e_di);
    chk("busy", busy, e_busy);
    chk("timeout", timeout, m_to);
    chk("dout", dout, twi_do);
  endtask

  task automatic model_step();
    bit set_lock [2];
    bit e0, e1;
    set_lock[0] = 0; set_lock[1] = 0;
    m_to = 0;
    if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_last = m_own; m_own = -1; m_arb_at = m_cyc + 1 + GAP;
      end else if (m_since == T - 1 && !twi_done) begin
        set_lock[m_own] = 1; m_to = 1;
        m_last = m_own; m_own = -1; m_arb_at = m_cyc + 1 + GAP;
      end else begin
        m_since = twi_done ? 0 : m_since + 1;
      end
    end else if (m_cyc >= m_arb_at) begin
      e0 = req[0] && !m_lock[0];
      e1 = req[1] && !m_lock[1];
      if (e0 && e1) m_own = 1 - m_last;
      else if (e0)  m_own = 0;
      else if (e1)  m_own = 1;
      if (m_own >= 0) m_since = 0;
    end
    for (int k = 0; k < 2; k++) m_lock[k] = (m_lock[k] || set_lock[k]) && req[k];
    m_cyc++;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    @(negedge clk_fpga);
    if (!reset) model_check();
    @(posedge clk_fpga);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clear_inputs();
    req = 0; stb = 0; msg = 0; addr = 0; di = 0;
    twi_do = 0; twi_done = 0; twi_err = 0;
  endtask

  task automatic run_random(input int n, input int flip, input int dprob);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, flip - 1) == 0) req[k] = ~req[k];
      stb      = 2'($urandom);
      msg      = 2'($urandom);
      addr     = 16'($urandom);
      di       = 16'($urandom);
      twi_do   = 8'($urandom);
      twi_done = ($urandom_range(0, dprob - 1) == 0);
      twi_err  = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0;
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    clear_inputs();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_twi_stb", twi_stb, 0);
    repeat (9) tick();

    // Port 0 alone: 3-byte read, with port 1 queued and strobing behind it.
    req = 2'b01;
    tick();
    chk("p0_grant", gnt, 2'b01);
    addr = 16'h8097; di = 16'h5500; msg[0] = 1;
    req[1] = 1; stb[1] = 1;
    for (int b = 0; b < 3; b++) begin
      stb[0] = 1;
      tick();
      chk("p0_addr", twi_addr, 8'h97);
      chk("p0_stb", twi_stb, 1);
      tick();
      twi_done = 1; twi_do = 8'(8'h10 + b);
      #1;
      chk("p0_done", done, 2'b01);
      chk("p0_dout", dout, 8'(8'h10 + b));
      tick();
      twi_done = 0; msg[0] = 0;
    end
    stb[0] = 0; req[0] = 0;
    tick();
    chk("gap_gnt0", gnt, 0);
    repeat (4) begin
      tick();
      chk("gap_gnt", gnt, 0);
    end
    tick();
    chk("p1_grant", gnt, 2'b10);
    chk("p1_addr", twi_addr, 8'h80);
    twi_done = 1;
    #1;
    chk("p1_done", done, 2'b10);
    tick();
    twi_done = 0;
    req[1] = 0; stb[1] = 0;
    tick();
    req = 2'b11;
    repeat (4) tick();
    tick();
    chk("round3_grant", gnt, 2'b01);
    clear_inputs();
    repeat (8) tick();

    // Watchdog: port 0 strobes and the master never answers.
    req = 2'b01;
    tick();
    chk("wd_grant", gnt, 2'b01);
    req[1] = 1; stb[0] = 1;
    repeat (T - 1) begin
      tick();
      chk("wd_early_to", timeout, 0);
    end
    tick();
    chk("wd_timeout", timeout, 1);
    chk("wd_gnt_drop", gnt, 0);
    repeat (4) tick();
    chk("wd_to_pulse", timeout, 0);
    tick();
    chk("wd_p1_grant", gnt, 2'b10);
    req[1] = 0;
    repeat (10) tick();
    chk("wd_lockout", gnt, 0);
    req[0] = 0;
    tick();
    req[0] = 1;
    tick();
    chk("wd_regrant", gnt, 2'b01);

    // Completion on the terminal watchdog cycle keeps ownership.
    repeat (T - 1) tick();
    twi_done = 1;
    #1;
    chk("term_stb", twi_stb, 1);
    tick();
    twi_done = 0;
    chk("term_no_to", timeout, 0);
    chk("term_gnt", gnt, 2'b01);
    repeat (T - 1) tick();
    tick();
    chk("term_late_to", timeout, 1);
    clear_inputs();
    repeat (8) tick();

    // Reset in the middle of an owned transfer.
    req = 2'b01;
    tick();
    stb[0] = 1; addr[7:0] = 8'h97;
    tick();
    chk("mid_stb", twi_stb, 1);
    req = 2'b11;
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stb", twi_stb, 0);
    tick();
    chk("post_rst_grant", gnt, 2'b01);
    clear_inputs();
    repeat (8) tick();

    // Randomized traffic: busy master, then a sluggish one to provoke timeouts.
    run_random(3000, 20, 8);
    run_random(3000, 80, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
